// File: rtl/mips8_pkg.sv
// Shared MIPS8 definitions: datapath widths, bubble word, HALT encoding,
// fetch FSM states and the opcode field that decode also slices.
package mips8_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_WORD    = 16'h0000;
  localparam logic [3:0]         HALT_OPCODE = 4'hF;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between two stages: instruction, its pc+1 and a valid
// flag. bubble beats hold beats load; with no control asserted it holds.
module if_id_reg #(
  parameter int                 INSTR_W  = 16,
  parameter int                 ADDR_W   = 8,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               bubble,
  input  logic               load,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [ADDR_W-1:0]  next_pc_plus1,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               valid
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr    <= NOP_WORD;
      pc_plus1 <= '0;
      valid    <= 1'b0;
    end else if (bubble) begin
      // pc_plus1 is meaningless without valid, so it is left untouched.
      instr <= NOP_WORD;
      valid <= 1'b0;
    end else if (load && !hold) begin
      instr    <= next_instr;
      pc_plus1 <= next_pc_plus1;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS8 instruction fetch: owns the PC, drives the async instruction memory
// and fills IF/ID, handling stall, flush, redirect and the HALT opcode.
module fetch_stage
  import mips8_pkg::*;
#(
  parameter int                 ADDR_W      = mips8_pkg::ADDR_W,
  parameter int                 INSTR_W     = mips8_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD    = mips8_pkg::NOP_WORD,
  parameter logic [3:0]         HALT_OPCODE = mips8_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic               if_valid,
  output logic               halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              halted_q, halted_d;
  logic              ifid_hold, ifid_bubble, ifid_load;

  assign pc_inc    = pc_q + 1'b1;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign halted    = halted_q;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halted_d    = 1'b0;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_load   = 1'b0;
    unique case (state_q)
      FETCH_BOOT: begin
        ifid_bubble = 1'b1;
        state_d     = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (redirect_valid) begin
          pc_d        = redirect_pc;
          ifid_bubble = 1'b1;
        end else if (flush) begin
          ifid_bubble = 1'b1;
          if (!stall) pc_d = pc_inc;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          // The HALT word itself is delivered to decode; fetch stops after it.
          ifid_load = 1'b1;
          pc_d      = pc_inc;
          if (opcode_of(imem_data) == HALT_OPCODE) state_d = FETCH_HALT;
        end
      end
      FETCH_HALT: begin
        ifid_bubble = 1'b1;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = FETCH_RUN;
        end else begin
          halted_d = 1'b1;
        end
      end
      default: begin
        ifid_bubble = 1'b1;
        state_d     = FETCH_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH_BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg #(
    .INSTR_W  (INSTR_W),
    .ADDR_W   (ADDR_W),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (ifid_hold),
    .bubble        (ifid_bubble),
    .load          (ifid_load),
    .next_instr    (imem_data),
    .next_pc_plus1 (pc_inc),
    .instr         (if_instr),
    .pc_plus1      (if_pc_plus1),
    .valid         (if_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle-level behavioural model is
// compared every cycle, and directed sequences pin hand-computed values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        stall, flush, redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  pc;
  logic [15:0] if_instr;
  logic [7:0]  if_pc_plus1;
  logic        if_valid, halted;

  logic [15:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  // Model: mode 0 = boot, 1 = run, 2 = halt.
  int          m_mode;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic [7:0]  m_pc1;
  logic        m_valid;
  logic        m_halted;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .if_instr       (if_instr),
    .if_pc_plus1    (if_pc_plus1),
    .if_valid       (if_valid),
    .halted         (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 8'h00; m_instr = 16'h0000;
      m_pc1 = 8'h00; m_valid = 1'b0; m_halted = 1'b0;
    end else begin
      m_halted = (m_mode == 2) && !redirect_valid;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (redirect_valid) begin
        m_pc = redirect_pc; m_instr = 16'h0000; m_valid = 1'b0; m_mode = 1;
      end else if (m_mode == 2) begin
        m_instr = 16'h0000; m_valid = 1'b0;
      end else if (flush) begin
        m_instr = 16'h0000; m_valid = 1'b0;
        if (!stall) m_pc = m_pc + 8'd1;
      end else if (!stall) begin
        m_instr = mem[m_pc];
        m_valid = 1'b1;
        m_pc1   = m_pc + 8'd1;
        m_pc    = m_pc + 8'd1;
        if (m_instr[15:12] == 4'hF) m_mode = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_pc", pc, m_pc);
      check("model_imem_addr", imem_addr, m_pc);
      check("model_if_valid", if_valid, m_valid);
      check("model_if_instr", if_instr, m_instr);
      check("model_halted", halted, m_halted);
      if (m_valid) check("model_if_pc_plus1", if_pc_plus1, m_pc1);
    end
  end

  // Apply inputs, let one rising edge pass, return at the following negedge.
  task automatic tick(input logic r, input logic s, input logic f,
                      input logic rv, input logic [7:0] rp);
    rst_n = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input logic [7:0] p, input logic [15:0] i,
                     input logic v, input logic h);
    check({tag, "_pc"}, pc, p);
    check({tag, "_if_instr"}, if_instr, i);
    check({tag, "_if_valid"}, if_valid, v);
    check({tag, "_halted"}, halted, h);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
    mem[8'h10] = 16'hF123;

    tick(0, 0, 0, 0, 8'h00);
    check_en = 1'b1;
    lit("reset", 8'h00, 16'h0000, 1'b0, 1'b0);
    check("reset_if_pc_plus1", if_pc_plus1, 8'h00);

    // Boot, then free run
    tick(1, 0, 0, 0, 8'h00);
    lit("boot", 8'h00, 16'h0000, 1'b0, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("run0", 8'h01, 16'h1000, 1'b1, 1'b0);
    check("run0_if_pc_plus1", if_pc_plus1, 8'h01);
    tick(1, 0, 0, 0, 8'h00);
    lit("run1", 8'h02, 16'h1001, 1'b1, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("run2", 8'h03, 16'h1002, 1'b1, 1'b0);

    // Stall two cycles at pc=3
    tick(1, 1, 0, 0, 8'h00);
    lit("stall0", 8'h03, 16'h1002, 1'b1, 1'b0);
    tick(1, 1, 0, 0, 8'h00);
    lit("stall1", 8'h03, 16'h1002, 1'b1, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("unstall", 8'h04, 16'h1003, 1'b1, 1'b0);
    tick(1, 0, 0, 0, 8'h00);

    // Redirect beats stall at pc=5
    check("pre_redirect_pc", pc, 8'h05);
    tick(1, 1, 0, 1, 8'h40);
    lit("redirect", 8'h40, 16'h0000, 1'b0, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("redirect_fetch", 8'h41, 16'h1040, 1'b1, 1'b0);
    check("redirect_if_pc_plus1", if_pc_plus1, 8'h41);

    // Flush alone advances pc; flush with stall holds it
    tick(1, 0, 1, 0, 8'h00);
    lit("flush", 8'h42, 16'h0000, 1'b0, 1'b0);
    tick(1, 1, 1, 0, 8'h00);
    lit("stall_flush", 8'h42, 16'h0000, 1'b0, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("after_flush", 8'h43, 16'h1042, 1'b1, 1'b0);

    // Wrap-around
    tick(1, 0, 0, 1, 8'hFE);
    lit("wrap0", 8'hFE, 16'h0000, 1'b0, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("wrap1", 8'hFF, 16'h10FE, 1'b1, 1'b0);
    check("wrap1_if_pc_plus1", if_pc_plus1, 8'hFF);
    tick(1, 0, 0, 0, 8'h00);
    lit("wrap2", 8'h00, 16'h10FF, 1'b1, 1'b0);
    check("wrap2_if_pc_plus1", if_pc_plus1, 8'h00);

    // HALT word under stall, then flush: not latched, so no halt
    tick(1, 0, 0, 1, 8'h10);
    tick(1, 1, 0, 0, 8'h00);
    lit("halt_stalled", 8'h10, 16'h0000, 1'b0, 1'b0);
    tick(1, 0, 1, 0, 8'h00);
    lit("halt_flushed", 8'h11, 16'h0000, 1'b0, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("halt_skipped", 8'h12, 16'h1011, 1'b1, 1'b0);

    // HALT entry
    tick(1, 0, 0, 1, 8'h0F);
    tick(1, 0, 0, 0, 8'h00);
    lit("pre_halt", 8'h10, 16'h100F, 1'b1, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("halt_word", 8'h11, 16'hF123, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1, i == 3, i == 6, 0, 8'h00);
      lit("halted", 8'h11, 16'h0000, 1'b0, 1'b1);
    end
    tick(1, 0, 0, 1, 8'h20);
    lit("halt_exit", 8'h20, 16'h0000, 1'b0, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("resume", 8'h21, 16'h1020, 1'b1, 1'b0);

    // Reset during HALT
    tick(1, 0, 0, 1, 8'h10);
    tick(1, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 8'h00);
    lit("halt_again", 8'h11, 16'h0000, 1'b0, 1'b1);
    tick(0, 0, 0, 0, 8'h00);
    lit("reset_in_halt", 8'h00, 16'h0000, 1'b0, 1'b0);
    check("reset_in_halt_if_pc_plus1", if_pc_plus1, 8'h00);
    tick(1, 0, 0, 0, 8'h00);
    lit("reboot", 8'h00, 16'h0000, 1'b0, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("rerun", 8'h01, 16'h1000, 1'b1, 1'b0);

    // Reset during stall
    tick(1, 0, 0, 0, 8'h00);
    tick(1, 1, 0, 0, 8'h00);
    lit("stall_pre_reset", 8'h02, 16'h1001, 1'b1, 1'b0);
    tick(0, 1, 0, 0, 8'h00);
    lit("reset_in_stall", 8'h00, 16'h0000, 1'b0, 1'b0);
    check("reset_in_stall_if_pc_plus1", if_pc_plus1, 8'h00);
    tick(1, 0, 0, 0, 8'h00);
    lit("reboot2", 8'h00, 16'h0000, 1'b0, 1'b0);
    tick(1, 0, 0, 0, 8'h00);
    lit("rerun2", 8'h01, 16'h1000, 1'b1, 1'b0);

    #2;
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
